muldiv_unit: RTL and testbench

// - Iterative multiply/divide unit for the EXE stage.
// - Produces a double-width result: HI = upper word or remainder, LO = lower word or quotient.
// - Holds busy while computing; the hazard unit uses busy to freeze IF/ID/EXE.
// - Successor to the single-cycle MUL/HIGH path: adds width parameter, signed/unsigned

---
 rtl/muldiv_unit.sv | 193 +++++++++++++++++++
 tb/tb_muldiv_unit.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative radix-2 multiply/divide unit (MULU, MUL, DIVU, DIV) with busy/done handshake.
// Optional macro MULDIV_FAST_ZERO_EN: zero operands skip the iteration phase.
module muldiv_unit #(
  parameter int WORD_LEN = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [1:0]          op,
  input  logic [WORD_LEN-1:0] src_a,
  input  logic [WORD_LEN-1:0] src_b,
  input  logic                flush,
  output logic                busy,
  output logic                done,
  output logic [WORD_LEN-1:0] hi,
  output logic [WORD_LEN-1:0] lo,
  output logic                div_by_zero
);

  localparam int CNT_W = $clog2(WORD_LEN) + 1;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WORD_LEN - 1);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_e;

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [WORD_LEN-1:0]   acc_q, acc_d;      // partial product high word / partial remainder
  logic [WORD_LEN-1:0]   mq_q, mq_d;        // multiplier / dividend shifting into quotient
  logic [WORD_LEN-1:0]   b_q, b_d;          // multiplicand / divisor magnitude
  logic [WORD_LEN-1:0]   a_raw_q, a_raw_d;
  logic                  is_div_q, is_div_d;
  logic                  neg_res_q, neg_res_d;
  logic                  neg_rem_q, neg_rem_d;
  logic                  zero_div_q, zero_div_d;
  logic [WORD_LEN-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic                  dbz_q, dbz_d, done_q, done_d;

  // Operand magnitudes and signs at start.
  logic                  a_neg, b_neg;
  logic [WORD_LEN-1:0]   a_mag, b_mag;

  assign a_neg = op[0] & src_a[WORD_LEN-1];
  assign b_neg = op[0] & src_b[WORD_LEN-1];
  assign a_mag = a_neg ? -src_a : src_a;
  assign b_mag = b_neg ? -src_b : src_b;

  // One iteration step for each operation.
  logic [WORD_LEN:0]     mul_sum, div_shift, div_diff;
  logic                  div_fits;

  assign mul_sum   = mq_q[0] ? ({1'b0, acc_q} + {1'b0, b_q}) : {1'b0, acc_q};
  assign div_shift = {acc_q, mq_q[WORD_LEN-1]};
  assign div_diff  = div_shift - {1'b0, b_q};
  assign div_fits  = ~div_diff[WORD_LEN];

  // Sign correction of the magnitude results.
  logic [2*WORD_LEN-1:0] prod_mag, prod_res;
  logic [WORD_LEN-1:0]   quo_res, rem_res;

  assign prod_mag = {acc_q, mq_q};
  assign prod_res = neg_res_q ? -prod_mag : prod_mag;
  assign quo_res  = neg_res_q ? -mq_q : mq_q;
  assign rem_res  = neg_rem_q ? -acc_q : acc_q;

`ifdef MULDIV_FAST_ZERO_EN
  logic zero_operand;
  assign zero_operand = op[1] ? (src_b == '0) : ((src_a == '0) || (src_b == '0));
`endif

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
    state_d    = state_q;
    count_d    = count_q;
    acc_d      = acc_q;
    mq_d       = mq_q;
    b_d        = b_q;
    a_raw_d    = a_raw_q;
    is_div_d   = is_div_q;
    neg_res_d  = neg_res_q;
    neg_rem_d  = neg_rem_q;
    zero_div_d = zero_div_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    dbz_d      = dbz_q;
    done_d     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_CALC;
          count_d    = '0;
          acc_d      = '0;
          mq_d       = a_mag;
          b_d        = b_mag;
          a_raw_d    = src_a;
          is_div_d   = op[1];
          neg_res_d  = a_neg ^ b_neg;
          neg_rem_d  = a_neg;
          zero_div_d = op[1] & (src_b == '0);
`ifdef MULDIV_FAST_ZERO_EN
          if (zero_operand) begin
            // A cleared accumulator pair is already the zero product.
            mq_d    = '0;
            state_d = S_FIX;
          end
`endif
        end
      end

      S_CALC: begin
        count_d = count_q + 1'b1;
        if (is_div_q) begin
          acc_d = div_fits ? div_diff[WORD_LEN-1:0] : div_shift[WORD_LEN-1:0];
          mq_d  = {mq_q[WORD_LEN-2:0], div_fits};
        end else begin
          acc_d = mul_sum[WORD_LEN:1];
          mq_d  = {mul_sum[0], mq_q[WORD_LEN-1:1]};
        end
        if (count_q == LAST_STEP) state_d = S_FIX;
      end

      S_FIX: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
        if (zero_div_q) begin
          hi_d  = a_raw_q;
          lo_d  = '1;
          dbz_d = 1'b1;
        end else if (is_div_q) begin
          hi_d  = rem_res;
          lo_d  = quo_res;
          dbz_d = 1'b0;
        end else begin
          {hi_d, lo_d} = prod_res;
          dbz_d        = 1'b0;
        end
      end

      default: state_d = S_IDLE;
    endcase

    // Flush aborts everything, including a pending result write.
    if (flush) begin
      state_d = S_IDLE;
      done_d  = 1'b0;
      hi_d    = hi_q;
      lo_d    = lo_q;
      dbz_d   = dbz_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      count_q    <= '0;
      acc_q      <= '0;
      mq_q       <= '0;
      b_q        <= '0;
      a_raw_q    <= '0;
      is_div_q   <= 1'b0;
      neg_res_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      zero_div_q <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      dbz_q      <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking so every register samples the pre-edge values of the others.
      state_q    <= state_d;
      count_q    <= count_d;
      acc_q      <= acc_d;
      mq_q       <= mq_d;
      b_q        <= b_d;
      a_raw_q    <= a_raw_d;
      is_div_q   <= is_div_d;
      neg_res_q  <= neg_res_d;
      neg_rem_q  <= neg_rem_d;
      zero_div_q <= zero_div_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      dbz_q      <= dbz_d;
      done_q     <= done_d;
    end
  end

  assign busy        = (state_q != S_IDLE);
  assign done        = done_q;
  assign hi          = hi_q;
  assign lo          = lo_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit at WORD_LEN=32.
// Latencies are counted in rising edges after the edge that samples start.
module tb_muldiv_unit;

  localparam int W = 32;
  localparam int LAT_FULL = W + 1;
`ifdef MULDIV_FAST_ZERO_EN
  localparam int LAT_ZERO = 1;
`else
  localparam int LAT_ZERO = W + 1;
`endif

  localparam logic [1:0] OP_MULU = 2'b00;
  localparam logic [1:0] OP_MUL  = 2'b01;
  localparam logic [1:0] OP_DIVU = 2'b10;
  localparam logic [1:0] OP_DIV  = 2'b11;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic [1:0]   op = 2'b00;
  logic [W-1:0] src_a = '0;
  logic [W-1:0] src_b = '0;
  logic         flush = 1'b0;
  logic         busy, done, div_by_zero;
  logic [W-1:0] hi, lo;

  int checks = 0;
  int failures = 0;

  muldiv_unit #(.WORD_LEN(W)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .src_a(src_a), .src_b(src_b),
    .flush(flush), .busy(busy), .done(done), .hi(hi), .lo(lo), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  // Inputs are driven and outputs sampled 1 ns after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Launches an op and scrambles the operand inputs afterwards.
  task automatic start_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    op = o; src_a = a; src_b = b; start = 1'b1;
    tick();
    start = 1'b0; src_a = ~a; src_b = ~b;
  endtask

  task automatic wait_done(input int base, output int cycles);
    cycles = base;
    do begin
      tick();
      cycles++;
    end while (done !== 1'b1 && cycles < 200);
  endtask

  task automatic do_op(input string name, input logic [1:0] o, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [W-1:0] exp_hi,
                       input logic [W-1:0] exp_lo, input logic exp_dbz, input int exp_lat);
    int cyc;
    start_op(o, a, b);
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL %s_busy: got %b expected 1", name, busy);
    end
    wait_done(0, cyc);
    checks++;
    if (cyc !== exp_lat) begin
      failures++;
      $display("FAIL %s_latency: got %0d expected %0d", name, cyc, exp_lat);
    end
    checks++;
    if ({busy, hi, lo, div_by_zero} !== {1'b0, exp_hi, exp_lo, exp_dbz}) begin
      failures++;
      $display("FAIL %s_result: got busy=%b hi=%h lo=%h dbz=%b expected busy=0 hi=%h lo=%h dbz=%b",
               name, busy, hi, lo, div_by_zero, exp_hi, exp_lo, exp_dbz);
    end
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if ({busy, done, hi, lo, div_by_zero} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got busy=%b done=%b hi=%h lo=%h dbz=%b expected all 0",
               busy, done, hi, lo, div_by_zero);
    end
    rst = 1'b1;
    tick();
    checks++;
    if ({busy, done} !== 2'b00) begin
      failures++;
      $display("FAIL reset_idle: got busy=%b done=%b expected 0 0", busy, done);
    end
  endtask

  task automatic test_multiply();
    do_op("mulu_max", OP_MULU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, LAT_FULL);
    do_op("mul_neg",  OP_MUL,  -32'sd7, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, LAT_FULL);
    do_op("mul_min",  OP_MUL,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0, 1'b0, LAT_FULL);
    do_op("mulu_mid", OP_MULU, 32'h0001_0000, 32'h0003_0005, 32'h0000_0003, 32'h0005_0000, 1'b0, LAT_FULL);
  endtask

  task automatic test_divide();
    do_op("div_neg",  OP_DIV,  -32'sd7, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, LAT_FULL);
    do_op("div_negb", OP_DIV,  32'd7, -32'sd2, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0, LAT_FULL);
    do_op("div_min",  OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0, LAT_FULL);
    do_op("divu_rem", OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, LAT_FULL);
    do_op("divu_big", OP_DIVU, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'h1, 1'b0, LAT_FULL);
  endtask

  task automatic test_div_zero();
    do_op("mulu_zero", OP_MULU, 32'd0, 32'd5, 32'h0, 32'h0, 1'b0, LAT_ZERO);
    do_op("divu_zero", OP_DIVU, 32'd100, 32'd0, 32'd100, 32'hFFFF_FFFF, 1'b1, LAT_ZERO);
    do_op("div_zero",  OP_DIV,  -32'sd5, 32'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b1, LAT_ZERO);
  endtask

  // Runs after test_div_zero, so the held outputs are hi=FFFFFFFB lo=FFFFFFFF dbz=1.
  task automatic test_flush();
    int pulses;
    start_op(OP_DIVU, 32'd10, 32'd3);
    repeat (9) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL flush_busy: got %b expected 0", busy);
    end
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      if (done === 1'b1) pulses++;
      tick();
    end
    checks++;
    if (pulses !== 0) begin
      failures++;
      $display("FAIL flush_no_done: got %0d done pulses expected 0", pulses);
    end
    checks++;
    if ({hi, lo, div_by_zero} !== {32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b1}) begin
      failures++;
      $display("FAIL flush_hold: got hi=%h lo=%h dbz=%b expected hi=fffffffb lo=ffffffff dbz=1",
               hi, lo, div_by_zero);
    end
    // Flush and start together: start is dropped.
    op = OP_DIVU; src_a = 32'd10; src_b = 32'd3; start = 1'b1; flush = 1'b1;
    tick();
    start = 1'b0; flush = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL flush_start_busy: got %b expected 0", busy);
    end
    do_op("divu_after_flush", OP_DIVU, 32'd10, 32'd3, 32'd1, 32'd3, 1'b0, LAT_FULL);
  endtask

  task automatic test_back_to_back();
    int cyc;
    start_op(OP_MULU, 32'd2, 32'd3);
    repeat (4) tick();
    op = OP_MULU; src_a = 32'd7; src_b = 32'd7; start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(5, cyc);
    checks++;
    if (cyc !== LAT_FULL) begin
      failures++;
      $display("FAIL b2b_first_latency: got %0d expected %0d", cyc, LAT_FULL);
    end
    checks++;
    if ({hi, lo} !== {32'd0, 32'd6}) begin
      failures++;
      $display("FAIL b2b_first_result: got hi=%h lo=%h expected hi=0 lo=6", hi, lo);
    end
    // Still in the done cycle: the next start must be accepted.
    do_op("b2b_divu", OP_DIVU, 32'd9, 32'd4, 32'd1, 32'd2, 1'b0, LAT_FULL);
  endtask

  // Held outputs are hi=1 lo=2 from the previous test.
  task automatic test_async_reset();
    start_op(OP_MULU, 32'd5, 32'd5);
    repeat (3) tick();
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({busy, done, hi, lo, div_by_zero} !== '0) begin
      failures++;
      $display("FAIL async_reset: got busy=%b done=%b hi=%h lo=%h dbz=%b expected all 0",
               busy, done, hi, lo, div_by_zero);
    end
    #2 rst = 1'b1;
    repeat (40) tick();
    checks++;
    if ({busy, done, hi, lo} !== '0) begin
      failures++;
      $display("FAIL async_reset_stays_idle: got busy=%b done=%b hi=%h lo=%h expected all 0",
               busy, done, hi, lo);
    end
  endtask

  initial begin
    test_reset();
    test_multiply();
    test_divide();
    test_div_zero();
    test_flush();
    test_back_to_back();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
